// File: rtl/add_tree_pkg.sv
// add_tree_pkg: shared defaults and count-width helper for the adder tree family
package add_tree_pkg;
  localparam int LANES_DEFAULT = 8;
  localparam int TREE_LATENCY_DEFAULT = 2;
  function automatic int count_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction
endpackage

// File: rtl/valid_delay.sv
// valid_delay: DEPTH-deep valid shift register with asynchronous reset
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic valid_o
);
  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH:0] shift;
  assign shift = {pipe_q, valid_i};
  assign valid_o = pipe_q[DEPTH-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) pipe_q <= '0;
    else pipe_q <= shift[DEPTH-1:0];
endmodule

// File: rtl/add_tree_gather.sv
// add_tree_gather: packs a valid-qualified sample stream into LANES-wide groups for the adder tree
module add_tree_gather
  import add_tree_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = LANES_DEFAULT,
  parameter int TREE_LATENCY = TREE_LATENCY_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_last,
  output logic [LANES-1:0][WIDTH-1:0]   outputs,
  output logic                          out_valid,
  output logic [count_w(LANES)-1:0]     out_count,
  output logic                          out_partial,
  output logic                          result_valid
);
  localparam int CW = $clog2(LANES);
  localparam int NW = count_w(LANES);
  logic [CW-1:0] cnt_q;
  logic [LANES-1:0][WIDTH-1:0] bank_q, outputs_q, outputs_d;
  logic [NW-1:0] count_q;
  logic valid_q, partial_q, close;
  assign outputs = outputs_q;
  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_partial = partial_q;
  // lanes above the closing sample are zeroed so they never disturb the sum
  always_comb begin
    close = in_valid && (in_last || cnt_q == CW'(LANES - 1));
    for (int i = 0; i < LANES; i++)
      outputs_d[i] = i < int'(cnt_q) ? bank_q[i] : i == int'(cnt_q) ? in_data : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      bank_q <= '0;
      outputs_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      valid_q <= close;
      if (close) begin
        outputs_q <= outputs_d;
        count_q <= NW'(cnt_q) + NW'(1);
        partial_q <= cnt_q != CW'(LANES - 1);
        cnt_q <= '0;
        bank_q <= '0;
      end else if (in_valid) begin
        bank_q[cnt_q] <= in_data;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  valid_delay #(.DEPTH(TREE_LATENCY)) u_valid_delay (
    .clk(clk),
    .rst(rst),
    .valid_i(valid_q),
    .valid_o(result_valid)
  );
endmodule

// File: tb/tb_add_tree_gather.sv
// tb_add_tree_gather: randomized and directed checks against a queue-based group model
module tb_add_tree_gather;
  localparam int W = 16;
  localparam int L = 8;
  localparam int TL = 2;
  localparam int NC = 8192;
  typedef logic [L*W-1:0] vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic [L-1:0][W-1:0] outs;
  logic out_valid, out_partial, result_valid;
  logic [3:0] out_count;
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  bit exp_ov [NC];
  bit exp_rv [NC];
  logic [W-1:0] m_bank [$];
  vec_t q_vec [$];
  int q_cnt [$];
  bit q_part [$];
  logic [W-1:0] q_sum [$];
  logic [W-1:0] q_res [$];
  int ov_cyc [$];
  logic [W-1:0] tree_q [TL];
  add_tree_gather dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .outputs(outs), .out_valid(out_valid), .out_count(out_count),
    .out_partial(out_partial), .result_valid(result_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] lane_sum(input logic [L-1:0][W-1:0] v);
    logic [W-1:0] s = '0;
    for (int i = 0; i < L; i++) s += v[i];
    return s;
  endfunction
  // behavioural stand-in for the adder tree: TL registered stages after the vector
  always @(posedge clk) begin
    tree_q[0] <= lane_sum(outs);
    for (int i = 1; i < TL; i++) tree_q[i] <= tree_q[i-1];
  end
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask
  task automatic model_step(input bit v, input logic [W-1:0] d, input bit l);
    vec_t e;
    logic [W-1:0] s;
    if (!v) return;
    m_bank.push_back(d);
    if (l || m_bank.size() == L) begin
      e = '0;
      s = '0;
      foreach (m_bank[i]) begin
        e[i*W +: W] = m_bank[i];
        s += m_bank[i];
      end
      q_vec.push_back(e);
      q_cnt.push_back(m_bank.size());
      q_part.push_back(m_bank.size() < L);
      q_sum.push_back(s);
      q_res.push_back(s);
      exp_ov[cyc_n] = 1'b1;
      exp_rv[cyc_n + TL] = 1'b1;
      m_bank.delete();
    end
  endtask
  task automatic check_cycle();
    check("out_valid", out_valid, exp_ov[cyc_n]);
    check("result_valid", result_valid, exp_rv[cyc_n]);
    if (out_valid) ov_cyc.push_back(cyc_n);
    if (out_valid && q_vec.size() > 0) begin
      check("outputs", outs, q_vec.pop_front());
      check("out_count", out_count, q_cnt.pop_front());
      check("out_partial", out_partial, q_part.pop_front());
      check("group_sum", lane_sum(outs), q_sum.pop_front());
    end
    if (result_valid && q_res.size() > 0) check("tree_result", tree_q[TL-1], q_res.pop_front());
  endtask
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit l);
    in_valid = v;
    in_data = d;
    in_last = l;
    @(posedge clk);
    cyc_n++;
    model_step(v, d, l);
    @(negedge clk);
    check_cycle();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_outputs"}, outs, '0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_partial"}, out_partial, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_result_valid"}, result_valid, 0);
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("rst_async");
    m_bank.delete();
    q_vec.delete(); q_cnt.delete(); q_part.delete(); q_sum.delete(); q_res.delete();
    for (int i = cyc_n; i < NC; i++) begin
      exp_ov[i] = 1'b0;
      exp_rv[i] = 1'b0;
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    check_reset_state("rst_hold");
    rst = 1'b0;
  endtask
  initial begin
    int rv_seen;
    #1 check_reset_state("por");
    @(posedge clk); cyc_n++;
    @(negedge clk); rst = 1'b0;
    idle(2);
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b0);
    idle(4);
    cyc(1'b1, 16'd5, 1'b0); cyc(1'b1, 16'd6, 1'b0); cyc(1'b1, 16'd7, 1'b1);
    idle(4);
    ov_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'hFFFF, 1'b0);
      if (i < 7) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'd1, 1'b0);
    idle(4);
    check("b2b_groups", ov_cyc.size(), 2);
    if (ov_cyc.size() >= 2) check("b2b_gap", ov_cyc[1] - ov_cyc[0], 8);
    ov_cyc.delete();
    cyc(1'b1, 16'd3, 1'b1); cyc(1'b1, 16'd4, 1'b1); cyc(1'b1, 16'd9, 1'b1);
    idle(4);
    check("last_each_groups", ov_cyc.size(), 3);
    if (ov_cyc.size() == 3) check("last_each_consec", ov_cyc[2] - ov_cyc[0], 2);
    for (int i = 0; i < 5; i++) cyc(1'b1, W'($urandom), 1'b0);
    do_reset();
    idle(2);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'd2, 1'b0);
    idle(4);
    for (int i = 0; i < 8; i++) cyc(1'b1, W'($urandom), 1'b0);
    cyc(1'b0, '0, 1'b0);
    do_reset();
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0);
      rv_seen += int'(result_valid);
    end
    check("rv_flushed", rv_seen, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 5) == 0);
    idle(TL + 2);
    check("res_queue_drained", q_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
